// File: rtl/wb_fib_ctrl_multi.sv
// rtl/wb_fib_ctrl_multi.sv - Wishbone control/status block for NUM_CH Fibonacci generator channels
module wb_fib_ctrl_multi #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          NUM_CH       = 2,
    parameter int          CLOCK_WIDTH  = 6,
    parameter int          VAL_WIDTH    = 30
) (
    input  logic                            wb_clk_i,
    input  logic                            reset,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_we_i,
    input  logic [3:0]                      wbs_sel_i,
    input  logic [31:0]                     wbs_adr_i,
    input  logic [31:0]                     wbs_dat_i,
    output logic                            wbs_ack_o,
    output logic [31:0]                     wbs_dat_o,
    input  logic [NUM_CH*VAL_WIDTH-1:0]     fib_val_i,
    output logic [NUM_CH-1:0]               switch_o,
    output logic [NUM_CH*CLOCK_WIDTH-1:0]   clock_sel_o,
    output logic                            irq_o,
    output logic                            panic_o
);

    localparam logic [31:0] CONFIG_VAL = {8'h02, 8'(NUM_CH), 8'(CLOCK_WIDTH), 8'(VAL_WIDTH)};
    localparam logic [31:0] ID_VAL     = 32'h4669_626f;
    localparam logic [31:0] STAT_BITS  = 32'h0003_0000 | ((32'd1 << NUM_CH) - 32'd1);

    logic                   ack_q;
    logic [31:0]            dat_q;
    logic [31:0]            status_q;
    logic [31:0]            mask_q;
    logic [31:0]            scratch_q;
    logic                   panic_q;
    logic [NUM_CH-1:0]      switch_q;
    logic [CLOCK_WIDTH-1:0] clk_sel_q [NUM_CH];
    logic [VAL_WIDTH-1:0]   thresh_q  [NUM_CH];
    logic [VAL_WIDTH-1:0]   val_q     [NUM_CH];
    logic [NUM_CH-1:0]      hits;

    logic [31:0] off;
    logic        hit;
    logic        access;
    logic        wr;
    logic [31:0] bm;
    logic [5:0]  widx;
    logic [3:0]  ch_sel;
    logic [1:0]  ch_reg;
    logic        ch_hit;
    logic [31:0] rdata;
    logic [31:0] status_set;
    logic [31:0] status_clr;
    logic [31:0] status_d;

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [31:0] m);
        return (old & ~m) | (nw & m);
    endfunction

    // Window check via offset so a BASE_ADDRESS near the top of the map cannot wrap.
    assign off    = wbs_adr_i - BASE_ADDRESS;
    assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i >= BASE_ADDRESS) & (off < 32'h100);
    assign access = hit & ~ack_q;
    assign wr     = access & wbs_we_i;
    assign bm     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign widx   = off[7:2];
    assign ch_sel = off[7:4] - 4'd4;
    assign ch_reg = off[3:2];
    assign ch_hit = (off[7:6] != 2'b00) && ({28'b0, ch_sel} < 32'(NUM_CH));

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign clock_sel_o[g*CLOCK_WIDTH +: CLOCK_WIDTH] = clk_sel_q[g];
            assign hits[g] = switch_q[g] & (thresh_q[g] != '0) & (val_q[g] >= thresh_q[g]);
        end
    endgenerate

    always_comb begin
        rdata = '0;
        case (widx)
            6'h00:   rdata = CONFIG_VAL;
            6'h01:   rdata = ID_VAL;
            6'h02:   rdata = status_q;
            6'h03:   rdata = mask_q;
            6'h05:   rdata = scratch_q;
            6'h06:   rdata = {31'b0, panic_q};
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_hit && ch_sel == 4'(c)) begin
                        case (ch_reg)
                            2'd0:    rdata = {31'b0, switch_q[c]};
                            2'd1:    rdata = 32'(clk_sel_q[c]);
                            2'd2:    rdata = 32'(val_q[c]);
                            default: rdata = 32'(thresh_q[c]);
                        endcase
                    end
                end
            end
        endcase
    end

    // Hardware sets are OR-ed after the clear so a coincident set always wins.
    always_comb begin
        status_set               = '0;
        status_set[NUM_CH-1:0]   = hits;
        status_set[16]           = wr && widx == 6'h04 && wbs_sel_i[0] && wbs_dat_i[0];
        status_set[17]           = panic_q | (wr && widx == 6'h06);
        status_clr               = (wr && widx == 6'h02) ? (wbs_dat_i & bm) : '0;
        status_d                 = ((status_q & ~status_clr) | status_set) & STAT_BITS;
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            scratch_q <= 32'hf00d_f00d;
            panic_q   <= 1'b0;
            switch_q  <= '1;
            for (int c = 0; c < NUM_CH; c++) begin
                clk_sel_q[c] <= CLOCK_WIDTH'(1);
                thresh_q[c]  <= '0;
                val_q[c]     <= '0;
            end
        end else begin
            ack_q    <= access;
            dat_q    <= (access && !wbs_we_i) ? rdata : '0;
            status_q <= status_d;
            for (int c = 0; c < NUM_CH; c++) begin
                val_q[c] <= fib_val_i[c*VAL_WIDTH +: VAL_WIDTH];
            end
            if (wr) begin
                case (widx)
                    6'h03:   mask_q    <= lane_merge(mask_q, wbs_dat_i, bm) & STAT_BITS;
                    6'h05:   scratch_q <= lane_merge(scratch_q, wbs_dat_i, bm);
                    6'h06:   panic_q   <= 1'b1;
                    default: begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (ch_hit && ch_sel == 4'(c)) begin
                                case (ch_reg)
                                    2'd0: if (wbs_sel_i[0]) switch_q[c] <= wbs_dat_i[0];
                                    2'd1: clk_sel_q[c] <= CLOCK_WIDTH'(lane_merge(
                                              32'(clk_sel_q[c]), wbs_dat_i, bm));
                                    2'd3: thresh_q[c] <= VAL_WIDTH'(lane_merge(
                                              32'(thresh_q[c]), wbs_dat_i, bm));
                                    default: ;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign switch_o  = switch_q;
    assign panic_o   = panic_q;
    assign irq_o     = |(status_q & mask_q);

endmodule

// File: tb/tb_wb_fib_ctrl_multi.sv
// tb/tb_wb_fib_ctrl_multi.sv - scoreboard bench for wb_fib_ctrl_multi
module tb_wb_fib_ctrl_multi;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        reset    = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_i = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [59:0] fib = '0;
    logic [1:0]  switch_o;
    logic [11:0] clock_sel;
    logic        irq, panic;

    typedef struct {
        bit          rd;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    wb_fib_ctrl_multi dut (
        .wb_clk_i   (wb_clk_i),
        .reset      (reset),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .fib_val_i  (fib),
        .switch_o   (switch_o),
        .clock_sel_o(clock_sel),
        .irq_o      (irq),
        .panic_o    (panic)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry; reads compare data.
    initial begin
        exp_t e;
        forever begin
            @(negedge wb_clk_i);
            if (ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {63'b0, ack}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.rd) chk($sformatf("rd_%0h", e.a), {32'b0, dat_o}, {32'b0, e.d});
                end
            end else if (reset === 1'b0) begin
                if (dat_o !== 32'h0) chk("dat_idle_zero", {32'b0, dat_o}, 64'd0);
            end
        end
    end

    task automatic bus(input logic [31:0] off, input bit w, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        e.rd = !w; e.a = off; e.d = exp;
        exp_q.push_back(e);
        adr = BASE + off; we = w; sel = s; dat_i = d; cyc = 1'b1; stb = 1'b1;
        @(posedge wb_clk_i); #1;
        chk("ack_latency", {63'b0, ack}, 64'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge wb_clk_i); #1;
        chk("ack_width", {63'b0, ack}, 64'd0);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp);
        bus(off, 1'b0, 4'hf, 32'h0, exp);
    endtask

    task automatic wr(input logic [31:0] off, input logic [3:0] s, input logic [31:0] d);
        bus(off, 1'b1, s, d, 32'h0);
    endtask

    task automatic no_ack_window(input logic [31:0] a);
        int n = 0;
        adr = a; we = 1'b0; sel = 4'hf; cyc = 1'b1; stb = 1'b1;
        repeat (8) begin
            @(posedge wb_clk_i); #1;
            if (ack === 1'b1) n++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk($sformatf("no_ack_%0h", a), 64'(n), 64'd0);
    endtask

    initial begin
        int n;
        exp_t e;
        repeat (3) @(posedge wb_clk_i);
        #1 reset = 1'b0;
        chk("rst_ack", {63'b0, ack}, 64'd0);
        chk("rst_switch", {62'b0, switch_o}, 64'h3);
        chk("rst_clock_sel", {52'b0, clock_sel}, 64'h041);
        chk("rst_irq", {63'b0, irq}, 64'd0);
        chk("rst_panic", {63'b0, panic}, 64'd0);

        rd(32'h00, 32'h0202_061e);
        rd(32'h04, 32'h4669_626f);
        rd(32'h14, 32'hf00d_f00d);
        rd(32'h08, 32'h0);
        wr(32'h14, 4'b0101, 32'h1122_3344);
        rd(32'h14, 32'hf022_f044);

        wr(32'h40, 4'hf, 32'h0);
        chk("switch_ch0_off", {62'b0, switch_o}, 64'h2);
        wr(32'h54, 4'h2, 32'h2a);
        chk("clksel_lane_ignored", {58'b0, clock_sel[11:6]}, 64'h01);
        wr(32'h54, 4'h1, 32'h2a);
        chk("clksel_lane0", {58'b0, clock_sel[11:6]}, 64'h2a);
        rd(32'h54, 32'h2a);

        // Threshold interrupt path on channel 0.
        wr(32'h40, 4'hf, 32'h1);
        wr(32'h4c, 4'hf, 32'd21);
        wr(32'h0c, 4'hf, 32'h1);
        fib = {30'd0, 30'd13};
        repeat (3) @(posedge wb_clk_i); #1;
        chk("irq_below_thresh", {63'b0, irq}, 64'd0);
        fib = {30'd0, 30'd21};
        @(posedge wb_clk_i); #1;
        chk("irq_edge1", {63'b0, irq}, 64'd0);
        @(posedge wb_clk_i); #1;
        chk("irq_edge2", {63'b0, irq}, 64'd1);
        rd(32'h48, 32'd21);
        rd(32'h08, 32'h1);
        wr(32'h08, 4'hf, 32'h1);
        chk("irq_reassert", {63'b0, irq}, 64'd1);
        rd(32'h08, 32'h1);
        fib = {30'd0, 30'd8};
        repeat (2) @(posedge wb_clk_i); #1;
        rd(32'h08, 32'h1);
        wr(32'h08, 4'hf, 32'h1);
        chk("irq_cleared", {63'b0, irq}, 64'd0);
        rd(32'h08, 32'h0);

        wr(32'h0c, 4'hf, 32'h0);
        wr(32'h10, 4'hf, 32'h1);
        rd(32'h08, 32'h0001_0000);
        chk("soft_irq_masked", {63'b0, irq}, 64'd0);
        wr(32'h0c, 4'hf, 32'h0001_0000);
        chk("soft_irq_unmasked", {63'b0, irq}, 64'd1);
        rd(32'h0c, 32'h0001_0000);
        wr(32'h08, 4'hf, 32'h0001_0000);
        chk("soft_irq_w1c", {63'b0, irq}, 64'd0);

        wr(32'h18, 4'hf, 32'h0);
        chk("panic_set", {63'b0, panic}, 64'd1);
        rd(32'h08, 32'h0002_0000);
        wr(32'h08, 4'hf, 32'h0002_0000);
        rd(32'h08, 32'h0002_0000);
        rd(32'h18, 32'h1);
        chk("panic_sticky", {63'b0, panic}, 64'd1);

        no_ack_window(BASE + 32'h100);
        no_ack_window(BASE - 32'h4);
        rd(32'h60, 32'h0);
        rd(32'h1c, 32'h0);
        wr(32'h6c, 4'hf, 32'hffff_ffff);
        rd(32'h4c, 32'd21);

        // Held strobe: acked every other cycle.
        e.rd = 1'b1; e.a = 32'h04; e.d = 32'h4669_626f;
        repeat (3) exp_q.push_back(e);
        n = 0;
        adr = BASE + 32'h04; we = 1'b0; sel = 4'hf; cyc = 1'b1; stb = 1'b1;
        repeat (6) begin
            @(posedge wb_clk_i); #1;
            if (ack === 1'b1) n++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("held_strobe_acks", 64'(n), 64'd3);
        @(posedge wb_clk_i); #1;

        // Reset during a write discards it.
        reset = 1'b1;
        adr = BASE + 32'h14; we = 1'b1; sel = 4'hf; dat_i = 32'h1234_5678; cyc = 1'b1; stb = 1'b1;
        @(posedge wb_clk_i); #1;
        chk("ack_after_reset", {63'b0, ack}, 64'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge wb_clk_i); #1;
        reset = 1'b0;
        chk("panic_reset", {63'b0, panic}, 64'd0);
        chk("switch_reset", {62'b0, switch_o}, 64'h3);
        chk("clksel_reset", {52'b0, clock_sel}, 64'h041);
        rd(32'h14, 32'hf00d_f00d);
        rd(32'h08, 32'h0);

        repeat (3) @(posedge wb_clk_i); #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
